// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - frame layout helpers and sender state encoding for serial_link
package link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } send_state_e;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  // Rounds up, so a link at least as wide as the frame needs a single beat.
  function automatic int beats(input int frame_bits, input int bus_w);
    return (frame_bits + bus_w - 1) / bus_w;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int write_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// rtl/link_fifo.sv - request FIFO with occupancy count and wrap-around pointers
module link_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/serial_link.sv
// rtl/serial_link.sv - queues requests, serializes them over a narrow link and deserializes them back
module serial_link
  import link_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int BUS_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_write,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  output logic                         out_write,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [DATA_W-1:0]            out_data,
  output logic                         done,
  output logic [BUS_W-1:0]             link_bus,
  output logic                         link_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int FRAME_W   = frame_w(ADDR_W, DATA_W);
  localparam int BEATS     = beats(FRAME_W, BUS_W);
  localparam int PAD_W     = BEATS * BUS_W;
  localparam int BCNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DATA_LSB  = data_lsb();
  localparam int ADDR_LSB  = addr_lsb(DATA_W);
  localparam int WRITE_BIT = write_bit(ADDR_W, DATA_W);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  logic [FRAME_W-1:0] head;
  logic               fifo_full, fifo_empty, fifo_pop;

  send_state_e        state_q, state_d;
  logic [PAD_W-1:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]  beat_q, beat_d;
  logic               send_valid;
  logic [BUS_W-1:0]   send_bus;

  logic [PAD_W-1:0]   rx_q, rx_d;
  logic [BCNT_W-1:0]  rbeat_q, rbeat_d;
  logic               out_valid_q, out_valid_d;
  logic               out_write_q, out_write_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  assign in_ready = !fifo_full;

  link_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .wdata ({in_write, in_addr, in_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign send_valid = (state_q == SEND);
  assign send_bus   = send_valid ? shift_q[BUS_W-1:0] : '0;

  // On the last beat the next frame is loaded directly so consecutive frames leave no gap.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    beat_d   = beat_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = PAD_W'(head);
          beat_d   = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (beat_q == LAST_BEAT) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = PAD_W'(head);
            beat_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_q >> BUS_W;
          beat_d  = beat_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beats enter at the top and slide down, so the first (LSB) beat ends at bit 0.
  always_comb begin
    rx_d        = rx_q;
    rbeat_d     = rbeat_q;
    out_valid_d = 1'b0;
    out_write_d = out_write_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (send_valid) begin
      rx_d = rx_q >> BUS_W;
      rx_d[PAD_W-1 -: BUS_W] = send_bus;
      if (rbeat_q == LAST_BEAT) begin
        rbeat_d     = '0;
        out_valid_d = 1'b1;
        out_write_d = rx_d[WRITE_BIT];
        out_addr_d  = rx_d[ADDR_LSB +: ADDR_W];
        out_data_d  = rx_d[DATA_LSB +: DATA_W];
      end else begin
        rbeat_d = rbeat_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      beat_q      <= '0;
      rx_q        <= '0;
      rbeat_q     <= '0;
      out_valid_q <= 1'b0;
      out_write_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      beat_q      <= beat_d;
      rx_q        <= rx_d;
      rbeat_q     <= rbeat_d;
      out_valid_q <= out_valid_d;
      out_write_q <= out_write_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign link_valid = send_valid;
  assign link_bus   = send_bus;
  assign out_valid  = out_valid_q;
  assign done       = out_valid_q;
  assign out_write  = out_write_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_serial_link.sv
// tb/tb_serial_link.sv - scoreboard bench for serial_link at link widths 8, 64 and 5
module tb_serial_link;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int FW     = 43;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_write = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;

  logic              d_in_ready, d_out_valid, d_out_write, d_done, d_link_valid;
  logic [ADDR_W-1:0] d_out_addr;
  logic [DATA_W-1:0] d_out_data;
  logic [7:0]        d_link_bus;
  logic [2:0]        d_fifo_count;

  logic              w_in_ready, w_out_valid, w_out_write, w_done, w_link_valid;
  logic [ADDR_W-1:0] w_out_addr;
  logic [DATA_W-1:0] w_out_data;
  logic [63:0]       w_link_bus;
  logic [2:0]        w_fifo_count;

  logic              o_in_ready, o_out_valid, o_out_write, o_done, o_link_valid;
  logic [ADDR_W-1:0] o_out_addr;
  logic [DATA_W-1:0] o_out_data;
  logic [4:0]        o_link_bus;
  logic [2:0]        o_fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [FW-1:0] sb_d[$];
  logic [FW-1:0] sb_w[$];
  logic [FW-1:0] sb_o[$];
  int            d_ov[$], w_ov[$], o_ov[$], d_lv[$], o_lv[$];
  logic [63:0]   d_bus[$], o_bus[$];

  serial_link u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
    .out_valid(d_out_valid), .out_write(d_out_write), .out_addr(d_out_addr),
    .out_data(d_out_data), .done(d_done), .link_bus(d_link_bus),
    .link_valid(d_link_valid), .fifo_count(d_fifo_count)
  );

  serial_link #(.BUS_W(64)) u_wide (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
    .out_valid(w_out_valid), .out_write(w_out_write), .out_addr(w_out_addr),
    .out_data(w_out_data), .done(w_done), .link_bus(w_link_bus),
    .link_valid(w_link_valid), .fifo_count(w_fifo_count)
  );

  serial_link #(.BUS_W(5)) u_odd (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(o_in_ready),
    .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
    .out_valid(o_out_valid), .out_write(o_out_write), .out_addr(o_out_addr),
    .out_data(o_out_data), .done(o_done), .link_bus(o_link_bus),
    .link_valid(o_link_valid), .fifo_count(o_fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (d_out_valid) begin
      if (sb_d.size() == 0) check("d_unexpected_out", d_out_valid, 0);
      else check("d_frame", {d_out_write, d_out_addr, d_out_data}, sb_d.pop_front());
      check("d_done", d_done, 1);
      d_ov.push_back(cyc);
    end else if (d_done) begin
      check("d_done_stray", d_done, 0);
    end
    if (d_link_valid) begin
      d_lv.push_back(cyc);
      d_bus.push_back(64'(d_link_bus));
    end else begin
      check("d_bus_idle", d_link_bus, 0);
    end
    check("d_ready_vs_full", d_in_ready, d_fifo_count != 3'd4);
    if (reset) sb_d.delete();
    else if (in_valid && d_in_ready) sb_d.push_back({in_write, in_addr, in_data});
  end

  always @(negedge clock) begin
    if (w_out_valid) begin
      if (sb_w.size() == 0) check("w_unexpected_out", w_out_valid, 0);
      else check("w_frame", {w_out_write, w_out_addr, w_out_data}, sb_w.pop_front());
      check("w_done", w_done, 1);
      w_ov.push_back(cyc);
    end
    if (!w_link_valid) check("w_bus_idle", w_link_bus, 0);
    if (reset) sb_w.delete();
    else if (in_valid && w_in_ready) sb_w.push_back({in_write, in_addr, in_data});
  end

  always @(negedge clock) begin
    if (o_out_valid) begin
      if (sb_o.size() == 0) check("o_unexpected_out", o_out_valid, 0);
      else check("o_frame", {o_out_write, o_out_addr, o_out_data}, sb_o.pop_front());
      check("o_done", o_done, 1);
      o_ov.push_back(cyc);
    end
    if (o_link_valid) begin
      o_lv.push_back(cyc);
      o_bus.push_back(64'(o_link_bus));
    end else begin
      check("o_bus_idle", o_link_bus, 0);
    end
    if (reset) sb_o.delete();
    else if (in_valid && o_in_ready) sb_o.push_back({in_write, in_addr, in_data});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_write = w;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic clear_logs();
    d_ov.delete(); w_ov.delete(); o_ov.delete();
    d_lv.delete(); o_lv.delete(); d_bus.delete(); o_bus.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (sb_d.size() == 0 && sb_w.size() == 0 && sb_o.size() == 0) break;
      step();
    end
    check(tag, sb_d.size() + sb_w.size() + sb_o.size(), 0);
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int t0;
    int acc;

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", d_in_ready, 1);
    check("rst_count", d_fifo_count, 0);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_link_valid", d_link_valid, 0);
    check("rst_out_data", d_out_data, 0);
    check("rst_wide_ready", w_in_ready, 1);
    step();

    // single write, all three widths
    clear_logs();
    t0 = cyc;
    drive(1'b1, 10'h155, 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    repeat (14) step();
    check("s1_lv_count", d_lv.size(), 6);
    check("s1_lv_first", d_lv[0] - t0, 2);
    check("s1_lv_last", d_lv[$] - t0, 7);
    check("s1_first_beat", d_bus[0], 64'hEF);
    check("s1_d_pulses", d_ov.size(), 1);
    check("s1_d_latency", d_ov[0] - t0, 8);
    check("s1_w_latency", w_ov[0] - t0, 3);
    check("s1_o_beats", o_lv.size(), 9);
    check("s1_o_first_beat", o_bus[0], 64'h0F);
    check("s1_o_latency", o_ov[0] - t0, 11);
    check("s1_hold_data", d_out_data, 32'hDEADBEEF);
    drain("s1_drain");

    // wide link read
    clear_logs();
    t0 = cyc;
    drive(1'b0, 10'h3FF, 32'h0);
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("s2_w_pulses", w_ov.size(), 1);
    check("s2_w_latency", w_ov[0] - t0, 3);
    check("s2_w_hold_write", w_out_write, 0);
    check("s2_w_hold_addr", w_out_addr, 10'h3FF);
    drain("s2_drain");

    // back-to-back
    clear_logs();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 10'(10'h100 + i), 32'hC0DE_0000 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (40) step();
    check("s3_d_pulses", d_ov.size(), 4);
    check("s3_d_first", d_ov[0] - t0, 8);
    for (int i = 1; i < 4; i++) check("s3_d_spacing", d_ov[i] - d_ov[i-1], 6);
    check("s3_lv_count", d_lv.size(), 24);
    check("s3_lv_span", d_lv[$] - d_lv[0], 23);
    check("s3_w_pulses", w_ov.size(), 4);
    check("s3_o_pulses", o_ov.size(), 4);
    drain("s3_drain");

    // full boundary: fill while the sender is busy with one frame
    clear_logs();
    drive(1'b1, 10'h001, 32'h1111_1111);
    step();
    in_valid = 1'b0;
    step();
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 10'(10'h010 + k), 32'hA000_0000 + 32'(k));
      @(negedge clock);
      acc += int'(d_in_ready);
      step();
    end
    check("s4_accepted", acc, 4);
    drive(1'b1, 10'h0FF, 32'hBAD0_BAD0);
    @(negedge clock);
    check("s4_ready_at_pop", d_in_ready, 0);
    check("s4_last_beat", d_link_valid, 1);
    step();
    in_valid = 1'b0;
    @(negedge clock);
    check("s4_count_after_pop", d_fifo_count, 3);
    step();
    drain("s4_drain");

    // reset mid-frame with requests queued
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'(10'h200 + i), 32'h5555_0000 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    drive(1'b1, 10'h077, 32'h7777_7777);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("s5_count", d_fifo_count, 0);
    check("s5_link_valid", d_link_valid, 0);
    check("s5_ready", d_in_ready, 1);
    check("s5_out_valid", d_out_valid, 0);
    step();
    repeat (14) step();
    check("s5_no_d_out", d_ov.size(), 0);
    check("s5_no_o_out", o_ov.size(), 0);
    clear_logs();
    t0 = cyc;
    drive(1'b1, 10'h2A5, 32'h1234_5678);
    step();
    in_valid = 1'b0;
    repeat (14) step();
    check("s5_new_pulses", d_ov.size(), 1);
    check("s5_new_latency", d_ov[0] - t0, 8);
    drain("s5_drain");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0)
        drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom);
      else
        in_valid = 1'b0;
      step();
    end
    in_valid = 1'b0;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
